alu_exec_ctrl: RTL
==================

// Module: alu_exec_ctrl
// PURPOSE
//  Parametrised successor to the single-cycle ALU control decoder. Decodes ALUOp_i/funct_i
//  into the 4-bit ALU code, executes the operation and returns a registered result.
//  Runs multi-cycle MUL (and optional DIV) iteratively, with a valid/ready handshake.
//  Sits in the EX stage; ready_o low stalls ID/EX.
// PARAMETERS
//  DATA_W       32  operand/result width (even, >=8)
//  MUL_STEP     1   multiplier bits retired per cycle; must divide DATA_W
// PORTS
//  clk_i      in   1       clock
//  rst_i      in   1       synchronous, active-low reset
//  valid_i    in   1       operation presented
//  ready_o    out  1       block can accept (high only in IDLE)
//  flush_i    in   1       synchronous abort of any in-flight op
//  ALUOp_i    in   3       main-decoder op class
//  funct_i    in   6       R-type funct field
//  src1_i     in   DATA_W  operand A (rs)
//  src2_i     in   DATA_W  operand B (rt / imm, extended upstream)
//  shamt_i    in   5       shift amount for sll
//  ALUCtrl_o  out  4       decoded code of the accepted op, registered
//  valid_o    out  1       one-cycle pulse: result_o/hi_o/zero_o/err_o valid
//  result_o   out  DATA_W  result (MUL low half, DIV quotient)
//  hi_o       out  DATA_W  MUL high half / DIV remainder, else 0
//  zero_o     out  1       result_o == 0
//  err_o      out  1       illegal ALUOp/funct combination
// BEHAVIOUR
//  Reset (rst_i==0 at clk edge): state IDLE, ready_o=1, every other output 0. Mid-op reset drops the op.
//  Decode: ALUOp 2 -> funct 32 add 0010, 34 sub 0110, 36 and 0000, 37 or 0001, 42 slt 0111,
//   0 sll 0011, 6 srlv 0100, 24 mul 1000, 8 jr 0101, 26 div 1011 (DIV only).
//   ALUOp 4 addi 0010, 1 branch 0110, 5 slti 0111, 3 lui 1001, 0 ori 1010, 6 bgez/bnez 1111, 7 jal 1110.
//  Unlisted funct under ALUOp 2 -> code 1100, err_o=1, result 0, latency 1.
//  Ops: add/sub wrap mod 2^DATA_W. slt signed, result 1/0. sll src2<<shamt_i.
//   srlv src2>>src1[$clog2(DATA_W)-1:0], logical. lui src2<<(DATA_W/2).
//   jr/jal/1111 pass src1. mul unsigned, 2*DATA_W product split hi/lo.
//  Handshake: accept when valid_i && ready_o && !flush_i. Inputs sampled only at acceptance.
//  FSM IDLE -> (single-cycle op) DONE -> IDLE: valid_o on the cycle after accept, latency 1, back-to-back ok.
//  IDLE -> (mul) MUL for DATA_W/MUL_STEP cycles -> DONE. valid_o at accept+DATA_W/MUL_STEP+1. ready_o=0 in MUL/DIV.
//  DONE: valid_o=1 for exactly one cycle. ready_o=1 in DONE, so a new accept is allowed that cycle.
//  flush_i: any state -> IDLE next cycle, valid_o suppressed. flush wins over simultaneous valid_i.
//  Outputs hold their last values between valid_o pulses.
// CONFIGURATION
//  ALU_EXEC_DIV_EN defined: funct 26 -> DIV state, restoring unsigned divide, DATA_W cycles + 1.
//   Divisor 0: quotient all-ones, remainder = dividend, same latency.
//  Not defined: funct 26 is illegal (code 1100, err_o=1, latency 1).
// STRUCTURE
//  Shared package alu_ctrl_pkg: 4-bit ALU code localparams, ALUOp class localparams,
//   funct localparams, FSM state encoding (IDLE/MUL/DIV/DONE).
//  Sub-module alu_iter_muldiv: shift-add multiplier (+ restoring divider under macro).
//   Ports: start, op, a, b, busy, done, lo, hi.
//  Top holds decode, single-cycle datapath, FSM and output registers.
// TESTING
//  add 0x7FFFFFFF+1 (ALUOp2,f32) -> valid_o next cycle, result 0x80000000, ALUCtrl_o 0010, zero_o 0.
//  sub 5-5 then slt -1<1 back-to-back -> two consecutive valid_o: result 0 with zero_o=1, then 1.
//  mul 0xFFFFFFFF*2, MUL_STEP=1 -> ready_o low 32 cycles; valid_o at +33; hi 1, lo 0xFFFFFFFE.
//  mul issued, flush_i at cycle 10 -> no valid_o, ready_o=1 next cycle; then add 1+1 -> 2.
//  ALUOp2 funct 63 -> err_o=1, ALUCtrl_o 1100, result 0; DIV off: funct 26 also err_o.
//  DIV_EN: 100/7 -> q 14, r 2 at +33; 9/0 -> q 0xFFFFFFFF, r 9. Reset mid-div -> all outputs 0.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared ALU control codes, op-class and funct encodings, FSM states and the decoder.
// Optional feature macro: ALU_EXEC_DIV_EN (funct 26 decodes to the iterative divide).
package alu_ctrl_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SLL  = 4'b0011;
  localparam logic [3:0] ALU_SRLV = 4'b0100;
  localparam logic [3:0] ALU_JR   = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_MUL  = 4'b1000;
  localparam logic [3:0] ALU_LUI  = 4'b1001;
  localparam logic [3:0] ALU_ORI  = 4'b1010;
  localparam logic [3:0] ALU_DIV  = 4'b1011;
  localparam logic [3:0] ALU_ILL  = 4'b1100;
  localparam logic [3:0] ALU_JAL  = 4'b1110;
  localparam logic [3:0] ALU_PASS = 4'b1111;

  localparam logic [2:0] OP_ORI    = 3'd0;
  localparam logic [2:0] OP_BRANCH = 3'd1;
  localparam logic [2:0] OP_RTYPE  = 3'd2;
  localparam logic [2:0] OP_LUI    = 3'd3;
  localparam logic [2:0] OP_ADDI   = 3'd4;
  localparam logic [2:0] OP_SLTI   = 3'd5;
  localparam logic [2:0] OP_BGEZ   = 3'd6;
  localparam logic [2:0] OP_JAL    = 3'd7;

  localparam logic [5:0] F_SLL  = 6'd0;
  localparam logic [5:0] F_SRLV = 6'd6;
  localparam logic [5:0] F_JR   = 6'd8;
  localparam logic [5:0] F_MUL  = 6'd24;
  localparam logic [5:0] F_ADD  = 6'd32;
  localparam logic [5:0] F_SUB  = 6'd34;
  localparam logic [5:0] F_AND  = 6'd36;
  localparam logic [5:0] F_OR   = 6'd37;
  localparam logic [5:0] F_SLT  = 6'd42;
`ifdef ALU_EXEC_DIV_EN
  localparam logic [5:0] F_DIV  = 6'd26;
`endif

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DONE} state_e;

  // Only the R-type class can be illegal; every other op class maps to a fixed code.
  function automatic logic [3:0] decode(input logic [2:0] alu_op, input logic [5:0] funct);
    logic [3:0] code;
    code = ALU_ILL;
    case (alu_op)
      OP_RTYPE: begin
        case (funct)
          F_ADD:   code = ALU_ADD;
          F_SUB:   code = ALU_SUB;
          F_AND:   code = ALU_AND;
          F_OR:    code = ALU_OR;
          F_SLT:   code = ALU_SLT;
          F_SLL:   code = ALU_SLL;
          F_SRLV:  code = ALU_SRLV;
          F_MUL:   code = ALU_MUL;
          F_JR:    code = ALU_JR;
`ifdef ALU_EXEC_DIV_EN
          F_DIV:   code = ALU_DIV;
`endif
          default: code = ALU_ILL;
        endcase
      end
      OP_ADDI:   code = ALU_ADD;
      OP_BRANCH: code = ALU_SUB;
      OP_SLTI:   code = ALU_SLT;
      OP_LUI:    code = ALU_LUI;
      OP_ORI:    code = ALU_ORI;
      OP_BGEZ:   code = ALU_PASS;
      OP_JAL:    code = ALU_JAL;
      default:   code = ALU_ILL;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/alu_exec_ctrl_if.sv
// Operand/handshake bus between the ID/EX pipeline register and the ALU execution controller.
interface alu_exec_ctrl_if #(parameter int DATA_W = 32);
  logic              valid_i;
  logic              ready_o;
  logic              flush_i;
  logic [2:0]        ALUOp_i;
  logic [5:0]        funct_i;
  logic [DATA_W-1:0] src1_i;
  logic [DATA_W-1:0] src2_i;
  logic [4:0]        shamt_i;
  logic [3:0]        ALUCtrl_o;
  logic              valid_o;
  logic [DATA_W-1:0] result_o;
  logic [DATA_W-1:0] hi_o;
  logic              zero_o;
  logic              err_o;

  modport master (
    output valid_i, flush_i, ALUOp_i, funct_i, src1_i, src2_i, shamt_i,
    input  ready_o, ALUCtrl_o, valid_o, result_o, hi_o, zero_o, err_o
  );

  modport slave (
    input  valid_i, flush_i, ALUOp_i, funct_i, src1_i, src2_i, shamt_i,
    output ready_o, ALUCtrl_o, valid_o, result_o, hi_o, zero_o, err_o
  );
endinterface

// File: rtl/alu_iter_muldiv.sv
// Iterative unsigned shift-add multiplier, MUL_STEP bits per cycle.
// With ALU_EXEC_DIV_EN defined it also holds a one-bit-per-cycle restoring divider.
module alu_iter_muldiv #(
  parameter int DATA_W   = 32,
  parameter int MUL_STEP = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              abort,
  input  logic              start,
  input  logic              op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] lo,
  output logic [DATA_W-1:0] hi
);

  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] MUL_CYCLES = CW'(DATA_W / MUL_STEP);

  logic [DATA_W-1:0]            opnd_q, hi_q, lo_q;
  logic [CW-1:0]                cnt_q;
  logic [DATA_W+MUL_STEP-1:0]   mul_upper;
  logic [2*DATA_W+MUL_STEP-1:0] mul_wide;

`ifdef ALU_EXEC_DIV_EN
  localparam logic [CW-1:0] DIV_CYCLES = CW'(DATA_W);
  logic          div_q;
  logic [DATA_W:0] div_shift, div_diff;
`else
  logic unused_op;
  assign unused_op = op;
`endif

  // lo/hi present the value the accumulator takes at the next edge, so the
  // consumer can capture the finished result on the same edge done is high.
  always_comb begin
    mul_upper = {{MUL_STEP{1'b0}}, hi_q}
              + ({{MUL_STEP{1'b0}}, opnd_q} * {{DATA_W{1'b0}}, lo_q[MUL_STEP-1:0]});
    mul_wide  = {mul_upper, lo_q};
    hi = mul_wide[2*DATA_W+MUL_STEP-1:DATA_W+MUL_STEP];
    lo = mul_wide[DATA_W+MUL_STEP-1:MUL_STEP];
`ifdef ALU_EXEC_DIV_EN
    div_shift = {hi_q, lo_q[DATA_W-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    if (div_q) begin
      if (!div_diff[DATA_W]) begin
        hi = div_diff[DATA_W-1:0];
        lo = {lo_q[DATA_W-2:0], 1'b1};
      end else begin
        hi = div_shift[DATA_W-1:0];
        lo = {lo_q[DATA_W-2:0], 1'b0};
      end
    end
`endif
  end

  assign done = busy && (cnt_q == CW'(1));

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      busy   <= 1'b0;
      cnt_q  <= '0;
      opnd_q <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
`ifdef ALU_EXEC_DIV_EN
      div_q  <= 1'b0;
`endif
    end else if (abort) begin
      busy  <= 1'b0;
      cnt_q <= '0;
    end else if (start) begin
      busy <= 1'b1;
      hi_q <= '0;
`ifdef ALU_EXEC_DIV_EN
      div_q  <= op;
      opnd_q <= op ? b : a;
      lo_q   <= op ? a : b;
      cnt_q  <= op ? DIV_CYCLES : MUL_CYCLES;
`else
      opnd_q <= a;
      lo_q   <= b;
      cnt_q  <= MUL_CYCLES;
`endif
    end else if (busy) begin
      hi_q  <= hi;
      lo_q  <= lo;
      cnt_q <= cnt_q - CW'(1);
      if (cnt_q == CW'(1)) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_exec_ctrl.sv
// EX-stage ALU controller: decode, single-cycle datapath, iterative MUL/DIV sequencing.
// Optional feature macro: ALU_EXEC_DIV_EN (enables funct 26 unsigned divide).
module alu_exec_ctrl #(
  parameter int DATA_W   = 32,
  parameter int MUL_STEP = 1
) (
  input logic             clk_i,
  input logic             rst_i,
  alu_exec_ctrl_if.slave  bus
);
  import alu_ctrl_pkg::*;

  localparam int SHW = $clog2(DATA_W);

  state_e            state_q;
  logic              ready_q, valid_q, zero_q, err_q;
  logic [3:0]        ctrl_q;
  logic [DATA_W-1:0] result_q, hi_q;

  logic [3:0]        dec_code;
  logic              dec_mul, dec_div, dec_err, accept, md_start;
  logic [DATA_W-1:0] alu_res;
  logic              md_busy, md_done;
  logic [DATA_W-1:0] md_lo, md_hi;

  assign dec_code = decode(bus.ALUOp_i, bus.funct_i);
  assign dec_mul  = (dec_code == ALU_MUL);
  assign dec_div  = (dec_code == ALU_DIV);
  assign dec_err  = (dec_code == ALU_ILL);
  assign accept   = bus.valid_i && ready_q && !bus.flush_i;
  assign md_start = accept && (dec_mul || dec_div);

  always_comb begin
    alu_res = '0;
    case (dec_code)
      ALU_ADD:                    alu_res = bus.src1_i + bus.src2_i;
      ALU_SUB:                    alu_res = bus.src1_i - bus.src2_i;
      ALU_AND:                    alu_res = bus.src1_i & bus.src2_i;
      ALU_OR, ALU_ORI:            alu_res = bus.src1_i | bus.src2_i;
      ALU_SLT:                    alu_res = {{(DATA_W-1){1'b0}}, ($signed(bus.src1_i) < $signed(bus.src2_i))};
      ALU_SLL:                    alu_res = bus.src2_i << bus.shamt_i;
      ALU_SRLV:                   alu_res = bus.src2_i >> bus.src1_i[SHW-1:0];
      ALU_LUI:                    alu_res = bus.src2_i << (DATA_W / 2);
      ALU_JR, ALU_JAL, ALU_PASS:  alu_res = bus.src1_i;
      default:                    alu_res = '0;
    endcase
  end

  alu_iter_muldiv #(.DATA_W(DATA_W), .MUL_STEP(MUL_STEP)) u_muldiv (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .abort (bus.flush_i),
    .start (md_start),
    .op    (dec_div),
    .a     (bus.src1_i),
    .b     (bus.src2_i),
    .busy  (md_busy),
    .done  (md_done),
    .lo    (md_lo),
    .hi    (md_hi)
  );

  // DONE accepts like IDLE so single-cycle ops can stream back-to-back.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q  <= ST_IDLE;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      ctrl_q   <= '0;
      result_q <= '0;
      hi_q     <= '0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
    end else if (bus.flush_i) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            ctrl_q <= dec_code;
            if (dec_mul || dec_div) begin
              state_q <= dec_div ? ST_DIV : ST_MUL;
              ready_q <= 1'b0;
            end else begin
              state_q  <= ST_DONE;
              ready_q  <= 1'b1;
              valid_q  <= 1'b1;
              result_q <= alu_res;
              hi_q     <= '0;
              zero_q   <= (alu_res == '0);
              err_q    <= dec_err;
            end
          end else begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
          end
        end
        ST_MUL, ST_DIV: begin
          if (md_done) begin
            state_q  <= ST_DONE;
            ready_q  <= 1'b1;
            valid_q  <= 1'b1;
            result_q <= md_lo;
            hi_q     <= md_hi;
            zero_q   <= (md_lo == '0);
            err_q    <= 1'b0;
          end else if (!md_busy) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ready_o   = ready_q;
  assign bus.valid_o   = valid_q;
  assign bus.ALUCtrl_o = ctrl_q;
  assign bus.result_o  = result_q;
  assign bus.hi_o      = hi_q;
  assign bus.zero_o    = zero_q;
  assign bus.err_o     = err_q;

endmodule
